// File: rtl/eth_idma_sched.sv
// Round-robin TX/RX descriptor scheduler in front of the iDMA 1D request port.
// It tracks in-flight transfers with an in-order tag FIFO and routes each response to its requester.
package idma_pkg;
  typedef enum logic [2:0] {
    AXI        = 3'd0,
    OBI        = 3'd1,
    AXI_STREAM = 3'd2,
    INIT       = 3'd3,
    TILELINK   = 3'd4,
    AXI_LITE   = 3'd5
  } protocol_e;
endpackage

module eth_idma_sched #(
  parameter int unsigned         AddrWidth      = 32,
  parameter int unsigned         TFLenWidth     = 32,
  parameter int unsigned         MaxOutstanding = 4,
  parameter idma_pkg::protocol_e ProtoAxi       = idma_pkg::AXI,
  parameter idma_pkg::protocol_e ProtoAxis      = idma_pkg::AXI_STREAM
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   tx_desc_valid_i,
  output logic                                   tx_desc_ready_o,
  input  logic [AddrWidth-1:0]                   tx_desc_addr_i,
  input  logic [TFLenWidth-1:0]                  tx_desc_len_i,
  input  logic                                   rx_desc_valid_i,
  output logic                                   rx_desc_ready_o,
  input  logic [AddrWidth-1:0]                   rx_desc_addr_i,
  input  logic [TFLenWidth-1:0]                  rx_desc_len_i,
  output logic                                   idma_req_valid_o,
  input  logic                                   idma_req_ready_i,
  output logic [TFLenWidth-1:0]                  idma_length_o,
  output logic [AddrWidth-1:0]                   idma_src_addr_o,
  output logic [AddrWidth-1:0]                   idma_dst_addr_o,
  output logic [2:0]                             idma_src_protocol_o,
  output logic [2:0]                             idma_dst_protocol_o,
  output logic                                   idma_last_o,
  input  logic                                   idma_rsp_valid_i,
  output logic                                   idma_rsp_ready_o,
  input  logic                                   idma_rsp_error_i,
  output logic                                   tx_done_valid_o,
  input  logic                                   tx_done_ready_i,
  output logic                                   tx_done_error_o,
  output logic                                   rx_done_valid_o,
  input  logic                                   rx_done_ready_i,
  output logic                                   rx_done_error_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
  output logic [7:0]                             err_cnt_o,
  output logic                                   busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);

  typedef enum logic {PrioTx = 1'b0, PrioRx = 1'b1} prio_e;
  typedef enum logic {TagTx = 1'b0, TagRx = 1'b1} tag_e;

  // Request slot
  logic                  req_valid_q, req_valid_d;
  logic [TFLenWidth-1:0] req_len_q, req_len_d;
  logic [AddrWidth-1:0]  req_src_q, req_src_d;
  logic [AddrWidth-1:0]  req_dst_q, req_dst_d;
  logic [2:0]            req_sproto_q, req_sproto_d;
  logic [2:0]            req_dproto_q, req_dproto_d;
  tag_e                  req_tag_q, req_tag_d;

  prio_e                 prio_q, prio_d;
  logic [CntWidth-1:0]   out_q, out_d;
  logic [7:0]            err_q, err_d;

  logic                  tx_done_v_q, tx_done_v_d, tx_done_e_q, tx_done_e_d;
  logic                  rx_done_v_q, rx_done_v_d, rx_done_e_q, rx_done_e_d;

  // Tag FIFO
  tag_e                  tags_q [MaxOutstanding];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic                  req_hs, rsp_ready, rsp_hs;
  logic                  slot_free, credit_ok, can_accept;
  logic                  grant_tx, grant_rx, accept, issue;
  logic [TFLenWidth-1:0] sel_len;
  tag_e                  head_tag;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign req_hs    = req_valid_q & idma_req_ready_i;
  assign head_tag  = tags_q[rd_ptr_q];
  assign rsp_ready = (fifo_cnt_q != '0) &&
                     ((head_tag == TagRx) ? (!rx_done_v_q || rx_done_ready_i)
                                          : (!tx_done_v_q || tx_done_ready_i));
  assign rsp_hs    = idma_rsp_valid_i & rsp_ready;

  // A popping response returns its credit in the same cycle.
  assign slot_free  = !req_valid_q || idma_req_ready_i;
  assign credit_ok  = (out_q < MaxCnt) || rsp_hs;
  assign can_accept = slot_free && credit_ok;
  assign grant_tx   = can_accept && tx_desc_valid_i && (!rx_desc_valid_i || prio_q == PrioTx);
  assign grant_rx   = can_accept && rx_desc_valid_i && (!tx_desc_valid_i || prio_q == PrioRx);
  assign accept     = grant_tx | grant_rx;
  assign sel_len    = grant_rx ? rx_desc_len_i : tx_desc_len_i;
  assign issue      = accept && (sel_len != '0);

  always_comb begin
    req_valid_d  = req_valid_q;
    req_len_d    = req_len_q;
    req_src_d    = req_src_q;
    req_dst_d    = req_dst_q;
    req_sproto_d = req_sproto_q;
    req_dproto_d = req_dproto_q;
    req_tag_d    = req_tag_q;
    prio_d       = prio_q;
    if (issue) begin
      req_valid_d = 1'b1;
      req_len_d   = sel_len;
      if (grant_tx) begin
        req_src_d    = tx_desc_addr_i;
        req_dst_d    = '0;
        req_sproto_d = ProtoAxi;
        req_dproto_d = ProtoAxis;
        req_tag_d    = TagTx;
        prio_d       = PrioRx;
      end else begin
        req_src_d    = '0;
        req_dst_d    = rx_desc_addr_i;
        req_sproto_d = ProtoAxis;
        req_dproto_d = ProtoAxi;
        req_tag_d    = TagRx;
        prio_d       = PrioTx;
      end
    end else if (req_hs) begin
      req_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_d      = out_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q;
    unique case ({issue, rsp_hs})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    unique case ({req_hs, rsp_hs})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (req_hs) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rsp_hs) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (rsp_hs && idma_rsp_error_i && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_comb begin
    tx_done_v_d = tx_done_v_q & ~tx_done_ready_i;
    tx_done_e_d = tx_done_e_q;
    rx_done_v_d = rx_done_v_q & ~rx_done_ready_i;
    rx_done_e_d = rx_done_e_q;
    if (rsp_hs) begin
      if (head_tag == TagRx) begin
        rx_done_v_d = 1'b1;
        rx_done_e_d = idma_rsp_error_i;
      end else begin
        tx_done_v_d = 1'b1;
        tx_done_e_d = idma_rsp_error_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_q  <= 1'b0;
      req_len_q    <= '0;
      req_src_q    <= '0;
      req_dst_q    <= '0;
      req_sproto_q <= '0;
      req_dproto_q <= '0;
      req_tag_q    <= TagTx;
      prio_q       <= PrioTx;
      out_q        <= '0;
      err_q        <= '0;
      tx_done_v_q  <= 1'b0;
      tx_done_e_q  <= 1'b0;
      rx_done_v_q  <= 1'b0;
      rx_done_e_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) tags_q[i] <= TagTx;
    end else begin
      req_valid_q  <= req_valid_d;
      req_len_q    <= req_len_d;
      req_src_q    <= req_src_d;
      req_dst_q    <= req_dst_d;
      req_sproto_q <= req_sproto_d;
      req_dproto_q <= req_dproto_d;
      req_tag_q    <= req_tag_d;
      prio_q       <= prio_d;
      out_q        <= out_d;
      err_q        <= err_d;
      tx_done_v_q  <= tx_done_v_d;
      tx_done_e_q  <= tx_done_e_d;
      rx_done_v_q  <= rx_done_v_d;
      rx_done_e_q  <= rx_done_e_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      if (req_hs) tags_q[wr_ptr_q] <= req_tag_q;
    end
  end

  assign tx_desc_ready_o     = grant_tx;
  assign rx_desc_ready_o     = grant_rx;
  assign idma_req_valid_o    = req_valid_q;
  assign idma_length_o       = req_len_q;
  assign idma_src_addr_o     = req_src_q;
  assign idma_dst_addr_o     = req_dst_q;
  assign idma_src_protocol_o = req_sproto_q;
  assign idma_dst_protocol_o = req_dproto_q;
  assign idma_last_o         = 1'b1;
  assign idma_rsp_ready_o    = rsp_ready;
  assign tx_done_valid_o     = tx_done_v_q;
  assign tx_done_error_o     = tx_done_e_q;
  assign rx_done_valid_o     = rx_done_v_q;
  assign rx_done_error_o     = rx_done_e_q;
  assign outstanding_o       = out_q;
  assign err_cnt_o           = err_q;
  assign busy_o              = (out_q != '0) || tx_done_v_q || rx_done_v_q;

endmodule

// File: tb/tb_eth_idma_sched.sv
// Bench for eth_idma_sched: directed scenarios with literal expectations plus
// a randomized phase, all checked each cycle against a queue-based reference model.
module tb_eth_idma_sched;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tx_v, rx_v, req_ready, rsp_valid, rsp_err, tx_dr, rx_dr;
  logic [31:0] tx_addr, tx_len, rx_addr, rx_len;
  logic        tx_rdy_o, rx_rdy_o, req_valid_o, last_o, rsp_ready_o;
  logic [31:0] len_o, src_o, dst_o;
  logic [2:0]  sp_o, dp_o;
  logic        txd_v_o, txd_e_o, rxd_v_o, rxd_e_o, busy_o;
  logic [2:0]  out_o;
  logic [7:0]  err_o;

  eth_idma_sched #(.MaxOutstanding(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_desc_valid_i(tx_v), .tx_desc_ready_o(tx_rdy_o),
    .tx_desc_addr_i(tx_addr), .tx_desc_len_i(tx_len),
    .rx_desc_valid_i(rx_v), .rx_desc_ready_o(rx_rdy_o),
    .rx_desc_addr_i(rx_addr), .rx_desc_len_i(rx_len),
    .idma_req_valid_o(req_valid_o), .idma_req_ready_i(req_ready),
    .idma_length_o(len_o), .idma_src_addr_o(src_o), .idma_dst_addr_o(dst_o),
    .idma_src_protocol_o(sp_o), .idma_dst_protocol_o(dp_o), .idma_last_o(last_o),
    .idma_rsp_valid_i(rsp_valid), .idma_rsp_ready_o(rsp_ready_o), .idma_rsp_error_i(rsp_err),
    .tx_done_valid_o(txd_v_o), .tx_done_ready_i(tx_dr), .tx_done_error_o(txd_e_o),
    .rx_done_valid_o(rxd_v_o), .rx_done_ready_i(rx_dr), .rx_done_error_o(rxd_e_o),
    .outstanding_o(out_o), .err_cnt_o(err_o), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending request, tag queue, credit count, done slots.
  typedef struct {
    logic [31:0] len, src, dst;
    logic [2:0]  sp, dp;
    bit          tag;
  } req_t;
  typedef struct packed {bit tx; bit rx; bit rsp;} rdy_t;

  bit   m_req_v;
  req_t m_req;
  bit   m_tags[$];
  int   m_out;
  bit   m_prio_rx;
  bit   m_dv[2];
  bit   m_de[2];
  int   m_err;

  function automatic rdy_t m_comb();
    rdy_t r;
    bit   h, hs;
    r = '0;
    if (m_tags.size() != 0) begin
      h = m_tags[0];
      r.rsp = !m_dv[h] || (h ? rx_dr : tx_dr);
    end
    hs = rsp_valid && r.rsp;
    if ((!m_req_v || req_ready) && ((m_out < MAX) || hs)) begin
      if (tx_v && rx_v) begin
        r.tx = !m_prio_rx;
        r.rx = m_prio_rx;
      end else begin
        r.tx = tx_v;
        r.rx = rx_v;
      end
    end
    return r;
  endfunction

  initial begin
    forever begin
      rdy_t c;
      bit   rhs, qhs, h;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_req_v = 0; m_tags.delete(); m_out = 0; m_prio_rx = 0;
        m_dv[0] = 0; m_dv[1] = 0; m_de[0] = 0; m_de[1] = 0; m_err = 0;
      end else begin
        c   = m_comb();
        rhs = rsp_valid && c.rsp;
        qhs = m_req_v && req_ready;
        if (m_dv[0] && tx_dr) m_dv[0] = 0;
        if (m_dv[1] && rx_dr) m_dv[1] = 0;
        if (rhs) begin
          h = m_tags.pop_front();
          m_dv[h] = 1;
          m_de[h] = rsp_err;
          if (rsp_err && m_err < 255) m_err++;
          m_out--;
        end
        if (qhs) begin
          m_tags.push_back(m_req.tag);
          m_req_v = 0;
        end
        if (c.tx && tx_len != 0) begin
          m_req.len = tx_len; m_req.src = tx_addr; m_req.dst = 0;
          m_req.sp = 3'd0; m_req.dp = 3'd2; m_req.tag = 0;
          m_req_v = 1; m_out++; m_prio_rx = 1;
        end else if (c.rx && rx_len != 0) begin
          m_req.len = rx_len; m_req.src = 0; m_req.dst = rx_addr;
          m_req.sp = 3'd2; m_req.dp = 3'd0; m_req.tag = 1;
          m_req_v = 1; m_out++; m_prio_rx = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      rdy_t c;
      @(negedge clk);
      if (rst_n) begin
        c = m_comb();
        chk("tx_desc_ready", tx_rdy_o, c.tx);
        chk("rx_desc_ready", rx_rdy_o, c.rx);
        chk("rsp_ready", rsp_ready_o, c.rsp);
        chk("req_valid", req_valid_o, m_req_v);
        if (m_req_v) begin
          chk("req_len", len_o, m_req.len);
          chk("req_src", src_o, m_req.src);
          chk("req_dst", dst_o, m_req.dst);
          chk("req_sproto", sp_o, m_req.sp);
          chk("req_dproto", dp_o, m_req.dp);
        end
        chk("last", last_o, 1'b1);
        chk("tx_done_valid", txd_v_o, m_dv[0]);
        if (m_dv[0]) chk("tx_done_error", txd_e_o, m_de[0]);
        chk("rx_done_valid", rxd_v_o, m_dv[1]);
        if (m_dv[1]) chk("rx_done_error", rxd_e_o, m_de[1]);
        chk("outstanding", out_o, m_out);
        chk("err_cnt", err_o, m_err);
        chk("busy", busy_o, (m_out != 0) || m_dv[0] || m_dv[1]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_v = 0; rx_v = 0; rsp_valid = 0; rsp_err = 0;
    tx_addr = 0; tx_len = 0; rx_addr = 0; rx_len = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, seq[16];
    bit errs[3];
    idle();
    req_ready = 0; tx_dr = 1; rx_dr = 1;
    #3;
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_last", last_o, 1);
    chk("rst_len", len_o, 0);
    chk("rst_src", src_o, 0);
    chk("rst_outstanding", out_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_ready", rsp_ready_o, 0);
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // Single TX
    tx_v = 1; tx_addr = 32'h1000; tx_len = 64;
    #2 chk("t1_tx_ready", tx_rdy_o, 1);
    cyc(); idle();
    #2;
    chk("t1_req_valid", req_valid_o, 1);
    chk("t1_src", src_o, 32'h1000);
    chk("t1_dst", dst_o, 0);
    chk("t1_len", len_o, 64);
    chk("t1_sproto", sp_o, 0);
    chk("t1_dproto", dp_o, 2);
    chk("t1_outstanding", out_o, 1);
    req_ready = 1;
    cyc(); req_ready = 0;
    rsp_valid = 1;
    #2 chk("t1_rsp_ready", rsp_ready_o, 1);
    cyc(); rsp_valid = 0;
    #2;
    chk("t1_tx_done", txd_v_o, 1);
    chk("t1_tx_err", txd_e_o, 0);
    chk("t1_out_zero", out_o, 0);
    cyc();
    chk("t1_idle", busy_o, 0);

    // Round-robin: last grant was TX, so RX leads.
    tx_v = 1; rx_v = 1; tx_len = 8; rx_len = 8; tx_addr = 32'h2000; rx_addr = 32'h3000;
    req_ready = 1; rsp_valid = 1;
    grants = 0;
    for (int i = 0; i < 16; i++) begin
      #2;
      seq[i] = rx_rdy_o ? 1 : 0;
      grants += int'(tx_rdy_o) + int'(rx_rdy_o);
      cyc();
    end
    chk("rr_grants", grants, 16);
    chk("rr_first", seq[0], 1);
    for (int i = 1; i < 16; i++) chk("rr_alternate", seq[i], 1 - seq[i-1]);
    idle(); rsp_valid = 1;
    repeat (6) cyc();
    rsp_valid = 0;
    cyc();

    // Credit limit
    tx_v = 1; tx_len = 16; tx_addr = 32'h4000; req_ready = 1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      #2 grants += int'(tx_rdy_o);
      cyc();
    end
    chk("cred_accepts", grants, 4);
    chk("cred_full_ready", tx_rdy_o, 0);
    rsp_valid = 1;
    #2 chk("cred_return_ready", tx_rdy_o, 1);
    cyc(); rsp_valid = 0;
    #2;
    chk("cred_ready_again0", tx_rdy_o, 0);
    chk("cred_outstanding", out_o, 4);
    idle(); rsp_valid = 1;
    repeat (8) cyc();
    rsp_valid = 0;
    cyc();
    chk("cred_drained", busy_o, 0);

    // Ordered routing TX, RX, TX
    tx_v = 1; tx_len = 4; tx_addr = 32'h5000;
    cyc(); idle();
    rx_v = 1; rx_len = 4; rx_addr = 32'h6000;
    cyc(); idle();
    tx_v = 1; tx_len = 4; tx_addr = 32'h7000;
    cyc(); idle();
    cyc(); cyc();
    chk("ord_outstanding", out_o, 3);
    errs[0] = 0; errs[1] = 1; errs[2] = 0;
    for (int i = 0; i < 3; i++) begin
      rsp_valid = 1; rsp_err = errs[i];
      cyc(); rsp_valid = 0; rsp_err = 0;
      #2;
      chk("ord_tx_done", txd_v_o, (i != 1));
      chk("ord_rx_done", rxd_v_o, (i == 1));
      chk("ord_error", (i == 1) ? rxd_e_o : txd_e_o, errs[i]);
    end
    chk("ord_err_cnt", err_o, 1);
    cyc();

    // Done back-pressure on RX
    rx_dr = 0;
    rx_v = 1; rx_len = 12; rx_addr = 32'h8000;
    cyc(); cyc(); idle();
    cyc(); cyc();
    rsp_valid = 1;
    #2 chk("bp_rsp_ready0", rsp_ready_o, 1);
    cyc();
    #2;
    chk("bp_rsp_blocked", rsp_ready_o, 0);
    chk("bp_rx_done", rxd_v_o, 1);
    cyc();
    #2 chk("bp_rsp_still_blocked", rsp_ready_o, 0);
    rx_dr = 1;
    #1 chk("bp_rsp_ready_rise", rsp_ready_o, 1);
    cyc(); rsp_valid = 0;
    #2 chk("bp_second_done", rxd_v_o, 1);
    cyc();
    #2;
    chk("bp_done_clear", rxd_v_o, 0);
    chk("bp_out_zero", out_o, 0);

    // Zero-length descriptor
    tx_v = 1; tx_len = 0; tx_addr = 32'h9000;
    #2 chk("zl_accept", tx_rdy_o, 1);
    cyc(); idle();
    #2;
    chk("zl_no_req", req_valid_o, 0);
    chk("zl_out", out_o, 0);
    rsp_valid = 1;
    repeat (3) cyc();
    rsp_valid = 0;
    chk("zl_no_done", txd_v_o, 0);

    // Reset with three transfers outstanding
    tx_v = 1; tx_len = 32; tx_addr = 32'hA000;
    repeat (3) cyc();
    idle();
    cyc();
    chk("rst_mid_out3", out_o, 3);
    rst_n = 0;
    #1;
    chk("rst_mid_req_valid", req_valid_o, 0);
    chk("rst_mid_out", out_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_rsp_ready", rsp_ready_o, 0);
    chk("rst_mid_len", len_o, 0);
    chk("rst_mid_src", src_o, 0);
    chk("rst_mid_err", err_o, 0);
    chk("rst_mid_last", last_o, 1);
    cyc(); rst_n = 1;
    cyc();

    // Randomized traffic, heavy on errors so the counter saturates
    for (int i = 0; i < 4000; i++) begin
      tx_v      = ($urandom % 4) != 0;
      tx_addr   = $urandom;
      tx_len    = (($urandom % 8) == 0) ? 32'd0 : $urandom;
      rx_v      = ($urandom % 4) != 0;
      rx_addr   = $urandom;
      rx_len    = (($urandom % 8) == 0) ? 32'd0 : $urandom;
      req_ready = ($urandom % 4) != 0;
      rsp_valid = ($urandom % 2) != 0;
      rsp_err   = ($urandom % 4) != 0;
      tx_dr     = ($urandom % 4) != 0;
      rx_dr     = ($urandom % 4) != 0;
      cyc();
    end
    idle();
    #2 chk("rand_err_saturated", err_o, 8'hFF);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
